// File: rtl/cpu_trace_fifo.sv
// cpu_trace_fifo
// Commit-trace capture buffer for the 16-bit single-cycle CPU. Each cycle it
// samples the retired instruction and, once a PC-match trigger has fired,
// stores it in an on-chip FIFO. The FIFO drains to a debug host over a
// valid/ready stream with show-ahead reads.
//
// Optional feature macro: TRACE_TIMESTAMP_EN
//   defined   -> a free-running 16-bit cycle stamp is prepended, out_data is 57 bits
//   undefined -> out_data is 41 bits
//
// Ports:
//   CLK, RESET      clock (rising edge), synchronous active-low reset
//   commit_*        retired instruction: valid, pc, op, rd, wdata, wreg
//   arm/stop/clear  control pulses (enter ARMED / go IDLE / flush FIFO+status)
//   stop_on_full    freeze capture once a push fills the FIFO
//   trig_pc         trigger PC, 16'hFFFF triggers on the first commit
//   out_valid/out_ready/out_data  drain stream, out_data = mem[rd_ptr]
//   count           occupancy 0..DEPTH
//   overflow        sticky dropped-commit flag
//   drop_cnt        saturating dropped-commit counter
//   state           IDLE=0, ARMED=1, RUN=2, FROZEN=3
module cpu_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          commit_valid,
    input  logic [15:0]   commit_pc,
    input  logic [3:0]    commit_op,
    input  logic [3:0]    commit_rd,
    input  logic [15:0]   commit_wdata,
    input  logic          commit_wreg,
    input  logic          arm,
    input  logic          stop,
    input  logic          clear,
    input  logic          stop_on_full,
    input  logic [15:0]   trig_pc,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef TRACE_TIMESTAMP_EN
    output logic [56:0]   out_data,
`else
    output logic [40:0]   out_data,
`endif
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [15:0]   drop_cnt,
    output logic [1:0]    state
);

`ifdef TRACE_TIMESTAMP_EN
    localparam int DW = 57;
`else
    localparam int DW = 41;
`endif
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_RUN    = 2'd2,
        S_FROZEN = 2'd3
    } state_t;

    state_t        cur_state;
    state_t        nxt_state;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_nxt;
    logic [DW-1:0] entry;
    logic          trig_hit;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          drop;

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] ts;

    always_ff @(posedge CLK) begin
        if (!RESET) ts <= '0;
        else        ts <= ts + 16'd1;
    end

    assign entry = {ts, commit_wreg, commit_pc, commit_op, commit_rd, commit_wdata};
`else
    assign entry = {commit_wreg, commit_pc, commit_op, commit_rd, commit_wdata};
`endif

    assign trig_hit = commit_valid && (commit_pc == trig_pc || trig_pc == 16'hFFFF);
    // The triggering commit in ARMED is itself captured.
    assign push_req = commit_valid &&
                      (cur_state == S_RUN || (cur_state == S_ARMED && trig_hit));
    // clear suppresses both push and pop in its cycle.
    assign pop      = !clear && out_valid && out_ready;
    assign push_ok  = !clear && push_req && (count != FULL || pop);
    assign drop     = !clear && push_req && !push_ok;

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop)      count_nxt = count + (AW+1)'(1);
        else if (pop && !push_ok) count_nxt = count - (AW+1)'(1);
    end

    always_ff @(posedge CLK) begin
        if (!RESET || clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= entry;
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET) cur_state <= S_IDLE;
        else        cur_state <= nxt_state;
    end

    // Next-state logic: clear holds state, stop beats arm
    always_comb begin
        nxt_state = cur_state;
        if (clear) begin
            nxt_state = cur_state;
        end else if (stop) begin
            nxt_state = S_IDLE;
        end else if (arm && (cur_state == S_IDLE || cur_state == S_FROZEN)) begin
            nxt_state = S_ARMED;
        end else begin
            case (cur_state)
                S_ARMED: if (trig_hit) nxt_state = S_RUN;
                S_RUN:   if (stop_on_full && push_ok && count_nxt == FULL)
                             nxt_state = S_FROZEN;
                default: nxt_state = cur_state;
            endcase
        end
    end

    // Outputs
    always_comb begin
        state     = cur_state;
        out_valid = (count != '0);
        out_data  = mem[rd_ptr];
    end

endmodule

// File: tb/tb_cpu_trace_fifo.sv
module tb_cpu_trace_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef TRACE_TIMESTAMP_EN
    localparam int DW = 57;
`else
    localparam int DW = 41;
`endif

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          commit_valid = 1'b0;
    logic [15:0]   commit_pc = '0;
    logic [3:0]    commit_op = '0;
    logic [3:0]    commit_rd = '0;
    logic [15:0]   commit_wdata = '0;
    logic          commit_wreg = 1'b0;
    logic          arm = 1'b0;
    logic          stop = 1'b0;
    logic          clear = 1'b0;
    logic          stop_on_full = 1'b0;
    logic [15:0]   trig_pc = 16'hFFFF;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;
    logic          overflow;
    logic [15:0]   drop_cnt;
    logic [1:0]    state;

    cpu_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(CLK), .RESET(RESET),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_op(commit_op),
        .commit_rd(commit_rd), .commit_wdata(commit_wdata), .commit_wreg(commit_wreg),
        .arm(arm), .stop(stop), .clear(clear), .stop_on_full(stop_on_full),
        .trig_pc(trig_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .count(count), .overflow(overflow),
        .drop_cnt(drop_cnt), .state(state)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: trace buffer as a queue, states as small integers
    logic [40:0] mq[$];
    logic [1:0]  mstate = 2'd0;
    logic        movf = 1'b0;
    int          mdrop = 0;

    task automatic model_step();
        bit trig, preq, mpop, acc;
        if (!RESET) begin
            mq.delete(); mstate = 2'd0; movf = 1'b0; mdrop = 0;
        end else if (clear) begin
            mq.delete(); movf = 1'b0; mdrop = 0;
        end else begin
            trig = commit_valid && (commit_pc == trig_pc || trig_pc == 16'hFFFF);
            preq = commit_valid && (mstate == 2 || (mstate == 1 && trig));
            mpop = (mq.size() != 0) && out_ready;
            acc  = preq && (mq.size() < DEPTH || mpop);
            if (mpop) void'(mq.pop_front());
            if (acc) mq.push_back({commit_wreg, commit_pc, commit_op, commit_rd, commit_wdata});
            else if (preq) begin
                movf = 1'b1;
                if (mdrop < 65535) mdrop++;
            end
            if (stop)                                      mstate = 2'd0;
            else if (arm && (mstate == 0 || mstate == 3))  mstate = 2'd1;
            else if (mstate == 1 && trig)                  mstate = 2'd2;
            else if (mstate == 2 && stop_on_full && acc && mq.size() == DEPTH) mstate = 2'd3;
        end
    endtask

    always @(posedge CLK) model_step();

    // Per-cycle comparison of every output against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            check("count", 64'(count), 64'(mq.size()));
            check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) check("out_data", 64'(out_data[40:0]), 64'(mq[0]));
            check("overflow", 64'(overflow), 64'(movf));
            check("drop_cnt", 64'(drop_cnt), 64'(mdrop));
            check("state", 64'(state), 64'(mstate));
        end
    end

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic do_commit(input logic [15:0] pc);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_op    = 4'($urandom);
        commit_rd    = 4'($urandom);
        commit_wdata = 16'($urandom);
        commit_wreg  = 1'($urandom);
        step();
        commit_valid = 1'b0;
    endtask

    task automatic pulse_arm();   arm = 1'b1;   step(); arm = 1'b0;   endtask
    task automatic pulse_stop();  stop = 1'b1;  step(); stop = 1'b0;  endtask
    task automatic pulse_clear(); clear = 1'b1; step(); clear = 1'b0; endtask

    function automatic logic [15:0] head_pc();
        logic [40:0] d;
        d = out_data[40:0];
        return d[39:24];
    endfunction

    initial begin
        int r;
        logic [15:0] exp_pc;

        // Reset
        RESET = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        RESET = 1'b1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_state", 64'(state), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);

        // Immediate trigger, three commits, no drain
        trig_pc = 16'hFFFF;
        pulse_arm();
        check("arm_state", 64'(state), 64'd1);
        do_commit(16'h0000);
        do_commit(16'h0002);
        do_commit(16'h0004);
        check("t1_count", 64'(count), 64'd3);
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_head_pc", 64'(head_pc()), 64'h0000);
        check("t1_state", 64'(state), 64'd2);
        check("t1_model_count", 64'(mq.size()), 64'd3);

        // PC-match trigger
        pulse_stop();
        pulse_clear();
        check("clr_state_idle", 64'(state), 64'd0);
        trig_pc = 16'h0010;
        pulse_arm();
        do_commit(16'h000C);
        do_commit(16'h000E);
        check("t2_pretrig_state", 64'(state), 64'd1);
        check("t2_pretrig_count", 64'(count), 64'd0);
        do_commit(16'h0010);
        check("t2_trig_state", 64'(state), 64'd2);
        check("t2_trig_count", 64'(count), 64'd1);
        check("t2_head_pc", 64'(head_pc()), 64'h0010);
        do_commit(16'h0012);
        check("t2_count", 64'(count), 64'd2);
        out_ready = 1'b1;
        step();
        check("t2_second_pc", 64'(head_pc()), 64'h0012);
        step();
        out_ready = 1'b0;
        check("t2_drained", 64'(count), 64'd0);

        // Overflow without freeze
        pulse_stop();
        pulse_clear();
        stop_on_full = 1'b0;
        trig_pc = 16'hFFFF;
        pulse_arm();
        for (int i = 0; i < 20; i++) do_commit(16'(2 * i));
        check("t3_count", 64'(count), 64'd16);
        check("t3_overflow", 64'(overflow), 64'd1);
        check("t3_drop_cnt", 64'(drop_cnt), 64'd4);
        check("t3_model_drop", 64'(mdrop), 64'd4);
        for (int i = 0; i < 16; i++) begin
            check("t3_drain_pc", 64'(head_pc()), 64'(2 * i));
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        check("t3_empty", 64'(out_valid), 64'd0);

        // Freeze on full
        pulse_stop();
        pulse_clear();
        stop_on_full = 1'b1;
        pulse_arm();
        for (int i = 0; i < 17; i++) begin
            do_commit(16'(2 * i));
            if (i == 15) check("t4_frozen", 64'(state), 64'd3);
        end
        check("t4_count", 64'(count), 64'd16);
        check("t4_drop_cnt", 64'(drop_cnt), 64'd0);
        check("t4_overflow", 64'(overflow), 64'd0);
        check("t4_model_state", 64'(mstate), 64'd3);
        pulse_arm();
        check("t4_rearm", 64'(state), 64'd1);

        // Push and pop together on a full FIFO
        stop_on_full = 1'b0;
        check("t5_head_before", 64'(head_pc()), 64'h0000);
        out_ready = 1'b1;
        do_commit(16'h0100);
        out_ready = 1'b0;
        check("t5_count", 64'(count), 64'd16);
        check("t5_drop_cnt", 64'(drop_cnt), 64'd0);
        check("t5_state", 64'(state), 64'd2);
        for (int i = 0; i < 16; i++) begin
            exp_pc = (i < 15) ? 16'(2 * (i + 1)) : 16'h0100;
            check("t5_drain_pc", 64'(head_pc()), 64'(exp_pc));
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;

        // Mid-stream reset, then clear
        pulse_stop();
        pulse_clear();
        pulse_arm();
        for (int i = 0; i < 5; i++) do_commit(16'(16'h0200 + 2 * i));
        check("t6_count_pre", 64'(count), 64'd5);
        RESET = 1'b0;
        step();
        RESET = 1'b1;
        check("t6_rst_count", 64'(count), 64'd0);
        check("t6_rst_out_valid", 64'(out_valid), 64'd0);
        check("t6_rst_state", 64'(state), 64'd0);
        check("t6_rst_overflow", 64'(overflow), 64'd0);
        pulse_arm();
        for (int i = 0; i < 5; i++) do_commit(16'(16'h0300 + 2 * i));
        check("t6_count_pre_clr", 64'(count), 64'd5);
        pulse_clear();
        check("t6_clr_count", 64'(count), 64'd0);
        check("t6_clr_state", 64'(state), 64'd2);

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            if (c % 100 == 0) begin
                stop_on_full = 1'($urandom_range(0, 1));
                trig_pc = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
            end
            r = $urandom_range(0, 99);
            arm   = (r < 4);
            stop  = (r >= 4 && r < 6);
            clear = (r >= 6 && r < 8);
            commit_valid = (r >= 8) && ($urandom_range(0, 3) != 0);
            commit_pc    = 16'($urandom_range(0, 15));
            commit_op    = 4'($urandom);
            commit_rd    = 4'($urandom);
            commit_wdata = 16'($urandom);
            commit_wreg  = 1'($urandom);
            out_ready    = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                                : ($urandom_range(0, 3) != 0);
            step();
        end
        arm = 1'b0; stop = 1'b0; clear = 1'b0; commit_valid = 1'b0; out_ready = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
